// File: rtl/universal_shift_register.sv
// WIDTH-bit register: hold/load/shift/rotate/clear plus a self-timed LSB-first burst serialiser.
// Optional feature macro: USR_PARITY_EN (even-parity output; tied to 0 when undefined).
module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = d;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = BURST;
                end else begin
                    case (mode)
                        3'b001:  q_d = d;
                        3'b010:  q_d = {q_q[WIDTH-2:0], ser_in_l};
                        3'b011:  q_d = {ser_in_r, q_q[WIDTH-1:1]};
                        3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                        3'b110:  q_d = '0;
                        default: q_d = q_q;
                    endcase
                end
            end
            BURST: begin
                // mode and start are deliberately not looked at while shifting out
                q_d   = {ser_in_r, q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign q           = q_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[WIDTH-1];
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef USR_PARITY_EN
    assign parity = ^q_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed plus randomized bench for universal_shift_register (WIDTH=8) against a word-level model.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       ser_in_l = 1'b0;
    logic       ser_in_r = 1'b0;
    logic       start = 1'b0;
    logic [7:0] q;
    logic       ser_out_lsb, ser_out_msb, busy, done, parity;

    int checks = 0;
    int errors = 0;

    // reference model state: word value, bits still to shift, flags
    logic [7:0] mq = 8'h00;
    int         mrem = 0;
    logic       mdone = 1'b0;

    universal_shift_register #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .d(d),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start),
        .q(q), .ser_out_lsb(ser_out_lsb), .ser_out_msb(ser_out_msb),
        .busy(busy), .done(done), .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] v);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(v[i]);
`ifdef USR_PARITY_EN
        return logic'(ones % 2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int v;
        v = int'(mq);
        mdone = 1'b0;
        if (reset) begin
            v = 0; mrem = 0;
        end else if (mrem > 0) begin
            v = (v / 2) + int'(ser_in_r) * 128;
            mrem--;
            mdone = (mrem == 0);
        end else if (start) begin
            v = int'(d); mrem = 8;
        end else begin
            case (int'(mode))
                1: v = int'(d);
                2: v = (v * 2 + int'(ser_in_l)) % 256;
                3: v = v / 2 + int'(ser_in_r) * 128;
                4: v = (v * 2) % 256 + v / 128;
                5: v = v / 2 + (v % 2) * 128;
                6: v = 0;
                default: ;
            endcase
        end
        mq = 8'(v);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"}, 64'(q), 64'(mq));
        chk({tag, ".lsb"}, 64'(ser_out_lsb), 64'(mq % 2));
        chk({tag, ".msb"}, 64'(ser_out_msb), 64'(mq / 128));
        chk({tag, ".busy"}, 64'(busy), 64'(mrem > 0));
        chk({tag, ".done"}, 64'(done), 64'(mdone));
        chk({tag, ".parity"}, 64'(parity), 64'(exp_parity(mq)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [7:0] pat;
        int         busy_cnt;
        int         done_cnt;
        logic [7:0] dv;

        // reset dominates a pending load
        #1;
        reset = 1'b1; mode = 3'b001; d = 8'hA5;
        tick("rst0"); tick("rst1");
        chk("rst_q", 64'(q), 64'h00);
        reset = 1'b0;
        tick("load_a5");
        chk("load_a5_q", 64'(q), 64'hA5);

        // shift and rotate from 0x81
        d = 8'h81; tick("load_81");
        mode = 3'b100; tick("rol"); chk("rol_q", 64'(q), 64'h03);
        mode = 3'b101; tick("ror"); chk("ror_q", 64'(q), 64'h81);
        mode = 3'b010; ser_in_l = 1'b1; tick("shl"); chk("shl_q", 64'(q), 64'h03);
        mode = 3'b011; ser_in_r = 1'b0; tick("shr"); chk("shr_q", 64'(q), 64'h01);

        // burst of 0xB4, LSB first
        mode = 3'b000; d = 8'hB4; start = 1'b1; tick("b1_start");
        start = 1'b0; ser_in_r = 1'b0;
        pat = 8'hB4; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b1_bit%0d", k), 64'(ser_out_lsb), 64'(pat[k]));
            chk($sformatf("b1_done_lo%0d", k), 64'(done), 64'h0);
            busy_cnt += int'(busy);
            tick("b1_shift");
        end
        chk("b1_busy_cycles", 64'(busy_cnt), 64'd8);
        chk("b1_done_hi", 64'(done), 64'h1);
        chk("b1_busy_lo", 64'(busy), 64'h0);
        chk("b1_final_q", 64'(q), 64'h00);
        tick("b1_after");
        chk("b1_done_once", 64'(done), 64'h0);

        // mode/start ignored during a burst
        d = 8'h5C; start = 1'b1; tick("b2_start");
        mode = 3'b110; ser_in_r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) start = 1'b0;
            tick("b2_shift");
            done_cnt += int'(done);
        end
        start = 1'b0; mode = 3'b000;
        for (int k = 0; k < 4; k++) begin
            tick("b2_tail");
            done_cnt += int'(done);
        end
        chk("b2_done_count", 64'(done_cnt), 64'd1);
        chk("b2_final_q", 64'(q), 64'hFF);

        // start beats mode=clear in idle
        dv = 8'($urandom_range(1, 255));
        d = dv; start = 1'b1; mode = 3'b110; tick("b3_start");
        chk("b3_q_is_d", 64'(q), 64'(dv));
        start = 1'b0; mode = 3'b000;
        for (int k = 0; k < 8; k++) tick("b3_shift");

        // back-to-back bursts via start in the done cycle
        chk("b3_done_cycle", 64'(done), 64'h1);
        d = 8'h3C; start = 1'b1; tick("b4_start");
        start = 1'b0; busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            busy_cnt += int'(busy);
            tick("b4_shift");
        end
        chk("b4_busy_cycles", 64'(busy_cnt), 64'd8);
        chk("b4_done", 64'(done), 64'h1);
        tick("b4_idle");

        // reset in burst cycle 4 aborts without done
        d = 8'hE7; start = 1'b1; tick("b5_start");
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick("b5_shift");
        reset = 1'b1; tick("b5_abort");
        chk("b5_abort_q", 64'(q), 64'h00);
        chk("b5_abort_busy", 64'(busy), 64'h0);
        reset = 1'b0; done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick("b5_post");
            done_cnt += int'(done);
        end
        chk("b5_no_done", 64'(done_cnt), 64'd0);

        // parity
        mode = 3'b001; d = 8'h07; tick("par07");
`ifdef USR_PARITY_EN
        chk("par07_val", 64'(parity), 64'h1);
`else
        chk("par07_val", 64'(parity), 64'h0);
`endif
        d = 8'h0F; tick("par0f");
        chk("par0f_val", 64'(parity), 64'h0);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 6) == 0);
            mode     = 3'($urandom_range(0, 7));
            d        = 8'($urandom_range(0, 255));
            ser_in_l = 1'($urandom_range(0, 1));
            ser_in_r = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the team's fixed 4-bit parallel-load register. It provides a WIDTH-bit register with hold, parallel load, logical shift and rotate in both directions, and synchronous clear. It also has a self-timed burst mode that loads a word and serialises it LSB-first with busy/done handshaking. It sits between parallel datapaths and serial links (SPI-style shifters, bit-serial test access) wherever a plain load register was used before.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  3  operation select (see Operation); ignored while busy or when start is accepted
- d  input  WIDTH  parallel data for load and burst start
- ser_in_l  input  1  bit entering q[0] on shift left
- ser_in_r  input  1  bit entering q[WIDTH-1] on shift right and during burst
- start  input  1  burst request; sampled only when busy=0
- q  output  WIDTH  register contents
- ser_out_lsb  output  1  q[0], combinational from q
- ser_out_msb  output  1  q[WIDTH-1], combinational from q
- busy  output  1  registered; high while a burst is shifting
- done  output  1  registered one-cycle pulse after a burst's final shift
- parity  output  1  even parity of q, XOR of all bits (see Configuration)

## Operation
- Priority at each clk edge: reset > active burst > start > mode.
- Reset: q=0, busy=0, done=0, burst counter=0, FSM=IDLE.
- Mode encoding (IDLE, start=0):
  - 000: hold.
  - 001: q<=d.
  - 010: shift left, q<={q[WIDTH-2:0],ser_in_l}.
  - 011: shift right, q<={ser_in_r,q[WIDTH-1:1]}.
  - 100: rotate left.
  - 101: rotate right.
  - 110: q<=0.
  - 111: hold (reserved).
- FSM has two states, IDLE and BURST.
  - IDLE, start=1: q<=d, cnt<=WIDTH, busy<=1, go to BURST. mode is ignored this edge.
  - BURST, each edge: shift right with ser_in_r, cnt<=cnt-1.
  - BURST, edge where cnt==1: perform the shift, busy<=0, done<=1, go to IDLE.
- done is 0 on every edge except the one described above.
- start and mode are ignored while busy=1; start is not queued.
- The counter is clog2(WIDTH+1) bits wide and never wraps; it is 0 in IDLE.
- Rotates and shifts discard nothing silently: the outgoing bit is visible on ser_out_* in the cycle before the edge.

## Timing
- Load, shift, rotate and clear have 1-cycle latency; q updates on the edge where mode is sampled.
- Burst timing:
  - Start edge at T: d appears on q, and busy is high for cycles T+1..T+WIDTH.
  - Bit k of d is on ser_out_lsb during cycle T+1+k (k=0..WIDTH-1).
  - The final shift occurs at edge T+WIDTH; done is high and busy is low during cycle T+WIDTH+1.
- Back-to-back bursts: start asserted during the done cycle is accepted, giving zero idle gap.
- Reset mid-burst aborts immediately. The next cycle shows q=0, busy=0, done=0, and no done pulse is produced.
- start and mode are never combinationally reflected on outputs.

## Configuration
- USR_PARITY_EN defined: parity = ^q, combinational, valid every cycle including reset (0).
- USR_PARITY_EN undefined: the parity port remains but is tied to 0, and no XOR tree is built.

## Test plan
- Reset: drive mode=001, d=0xA5, reset=1 for 2 cycles. Required: q=0x00, busy=0, done=0. Release reset, hold mode=001 for one edge. Required: q=0xA5.
- Shift/rotate:
  - q=0x81, mode=100 one edge -> q=0x03.
  - mode=101 one edge -> q=0x81.
  - mode=010 with ser_in_l=1 -> q=0x03.
  - mode=011 with ser_in_r=0 -> q=0x01.
- Burst: d=0xB4, start pulse at T.
  - ser_out_lsb over cycles T+1..T+8 reads 0,0,1,0,1,1,0,1.
  - busy is high for exactly 8 cycles.
  - done is high only at T+9.
  - With ser_in_r=0, final q=0x00.
- Ignore rules:
  - During a burst, drive mode=110 and start=1 on every cycle. Required: shifting is unaffected and exactly one done pulse occurs.
  - In IDLE, drive start=1 with mode=110. Required: the burst wins and q=d.
- Back-to-back and abort:
  - Assert start again during the done cycle. Required: a second burst with busy continuous except for the single done cycle.
  - Assert reset at burst cycle 4. Required: q=0, busy=0, and no done pulse.
- Parity: with USR_PARITY_EN, load q=0x07 -> parity=1, load q=0x0F -> parity=0. Without the macro, parity=0 for both.
